sync_debounce: RTL and testbench

- Conditions a raw asynchronous level input (push-button, switch, external strobe) into a clean, clock-synchronous level for downstream D flip-flop stages.
- Structure: multi-stage synchronizer, then a counter-based debounce state machine, then single-cycle rise/fall pulse generation.
- Sits directly upstream of the team's D flip-flop stages; dout drives their d input.

---
 rtl/sync_debounce_pkg.sv | 16 +
 rtl/sync_debounce_sync_chain.sv | 22 ++
 rtl/sync_debounce.sv | 113 +++++++++++
 tb/tb_sync_debounce.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared state encoding and default sizing for the
// synchronizer/debounce block.
package sync_debounce_pkg;

   // Bit 1 of the encoding is the debounced level, so dout follows state[1]
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b11,
      WAIT_LO   = 2'b10
   } db_state_e;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: plain flop shift chain for bringing an async level into the
// clk domain. No logic between stages so every stage can resolve.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   // Shift the raw level through the chain; last stage is the synchronized copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= {chain_q[STAGES-2:0], d};
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronizer -> counter debounce FSM -> rise/fall pulses.
// Optional push-on/push-off output toggle_q when SYNC_DEBOUNCE_TOGGLE_EN
// is defined.
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_async,
   input  logic sample_tick,
   output logic dout,
   output logic rise_pulse,
   output logic fall_pulse,
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
   output logic toggle_q,
`endif
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

   logic      sync_q;
   db_state_e state_q;
   logic [CNT_W-1:0] cnt_q;
   logic      dout_q, rise_q, fall_q, busy_q;
   logic      dout_d, busy_d;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (din_async),
      .q     (sync_q)
   );

   // Level and busy implied by the current state; registered below
   assign dout_d = (state_q == STABLE_HI) || (state_q == WAIT_LO);
   assign busy_d = (state_q == WAIT_HI)   || (state_q == WAIT_LO);

   // Debounce FSM with registered outputs; state and counter move only on ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         busy_q <= busy_d;
         rise_q <= dout_d & ~dout_q;
         fall_q <= ~dout_d & dout_q;
         if (sample_tick) begin
            case (state_q)
               STABLE_LO: if (sync_q) begin
                  state_q <= ONE_SHOT ? STABLE_HI : WAIT_HI;
                  cnt_q   <= ONE_SHOT ? '0 : CNT_ONE;
               end
               WAIT_HI: begin
                  if (!sync_q) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q + CNT_ONE;
                  end
               end
               STABLE_HI: if (!sync_q) begin
                  state_q <= ONE_SHOT ? STABLE_LO : WAIT_LO;
                  cnt_q   <= ONE_SHOT ? '0 : CNT_ONE;
               end
               WAIT_LO: begin
                  if (sync_q) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
   // Push-on/push-off: flip on each rise pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      toggle_q <= 1'b0;
      else if (rise_q) toggle_q <= ~toggle_q;
   end
`endif

   assign dout       = dout_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed bench for sync_debounce (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Expected {dout,rise,fall,busy} per cycle are queued
// when a cycle is driven and checked after the edge.
module tb_sync_debounce;

   logic clk = 1'b0;
   logic rst_n, din_async, sample_tick;
   logic dout, rise_pulse, fall_pulse, busy;
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
   logic toggle_q;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] v;   // {dout, rise, fall, busy}
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din_async   (din_async),
      .sample_tick (sample_tick),
      .dout        (dout),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
      .toggle_q    (toggle_q),
`endif
      .busy        (busy)
   );

   task automatic check_now();
      exp_t e;
      logic [3:0] obs;
      e = sb.pop_front();
      obs = {dout, rise_pulse, fall_pulse, busy};
      checks++;
      assert (obs === e.v) else begin
         errors++;
         $error("FAIL %s observed d/r/f/b=%b expected %b", e.tag, obs, e.v);
      end
   endtask

   // Drive one cycle, then compare after the edge
   task automatic run(input logic d, input logic t, input string tag, input logic [3:0] ev);
      exp_t e;
      e.tag = tag;
      e.v   = ev;
      sb.push_back(e);
      din_async   = d;
      sample_tick = t;
      @(posedge clk);
      #1;
      check_now();
   endtask

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
   task automatic chk_tog(input string tag, input logic ev);
      checks++;
      assert (toggle_q === ev) else begin
         errors++;
         $error("FAIL %s observed toggle=%b expected %b", tag, toggle_q, ev);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; din_async = 1'b1; sample_tick = 1'b1;

      // Reset held with input high: everything stays 0
      for (int i = 0; i < 5; i++) run(1'b1, 1'b1, $sformatf("rst_hold%0d", i), 4'b0000);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) run(1'b0, 1'b1, $sformatf("idle%0d", i), 4'b0000);

      // Clean rise: busy after edges 3..5, dout+rise after edge 6
      for (int i = 0; i < 10; i++)
         run(1'b1, 1'b1, $sformatf("rise_e%0d", i),
             {i >= 6, i == 6, 1'b0, (i >= 3 && i <= 5)});

      // Clean fall back to low, same timing
      for (int i = 0; i < 10; i++)
         run(1'b0, 1'b1, $sformatf("fall_e%0d", i),
             {i < 6, 1'b0, i == 6, (i >= 3 && i <= 5)});

      // Two-cycle high glitch: busy after edges 3,4 then rejected, no pulse
      for (int i = 0; i < 12; i++)
         run(i < 2, 1'b1, $sformatf("glitch_e%0d", i),
             {1'b0, 1'b0, 1'b0, (i == 3 || i == 4)});

      // Tick every 3rd cycle; one-cycle low glitch (din low before edge 5)
      // lands in sync_q only at non-tick edge 7. Qualifying ticks at 3,6,9,12.
      for (int i = 0; i < 18; i++)
         run(i != 5, (i % 3) == 0, $sformatf("tick_e%0d", i),
             {i >= 13, i == 13, 1'b0, (i >= 4 && i <= 12)});

      // Fall from high with fall_pulse at edge 6
      for (int i = 0; i < 10; i++)
         run(1'b0, 1'b1, $sformatf("fall2_e%0d", i),
             {i < 6, 1'b0, i == 6, (i >= 3 && i <= 5)});

      // Raise input, reset while in WAIT_HI (busy already high after edge 3)
      for (int i = 0; i < 4; i++)
         run(1'b1, 1'b1, $sformatf("pre_rst_e%0d", i), {3'b000, i == 3});
      rst_n = 1'b0;
      #1;
      sb.push_back('{tag: "async_rst", v: 4'b0000});
      check_now();
      for (int i = 0; i < 3; i++) run(1'b1, 1'b1, $sformatf("in_rst%0d", i), 4'b0000);
      rst_n = 1'b1;
      // Re-qualifies from zero with the input still high
      for (int i = 0; i < 10; i++)
         run(1'b1, 1'b1, $sformatf("requal_e%0d", i),
             {i >= 6, i == 6, 1'b0, (i >= 3 && i <= 5)});

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
      rst_n = 1'b0;
      #1;
      chk_tog("tog_rst", 1'b0);
      for (int i = 0; i < 2; i++) run(1'b0, 1'b1, $sformatf("tog_in_rst%0d", i), 4'b0000);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) run(1'b0, 1'b1, $sformatf("tog_idle%0d", i), 4'b0000);
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 10; i++)
            run(1'b1, 1'b1, $sformatf("press%0d_e%0d", p, i),
                {i >= 6, i == 6, 1'b0, (i >= 3 && i <= 5)});
         chk_tog($sformatf("tog_press%0d", p), (p % 2) == 0);
         for (int i = 0; i < 10; i++)
            run(1'b0, 1'b1, $sformatf("release%0d_e%0d", p, i),
                {i < 6, 1'b0, i == 6, (i >= 3 && i <= 5)});
         chk_tog($sformatf("tog_release%0d", p), (p % 2) == 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
